hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core. It generates the stall, flush and forwarding controls for the F/D, D/E, E/M and M/W pipeline registers. It covers load-use hazards, taken-branch/jump flushes, register forwarding into Execute, and a multi-cycle data-memory wait handshake with a timeout watchdog. It sits beside the datapath, takes register indices and control bits from each stage, and drives the enable/clear inputs of every pipeline register.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/hazard_fwd.sv | 14 +
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;
  localparam logic [1:0] RESULT_LOAD = 2'b01;
endpackage

// File: rtl/hazard_fwd.sv
// hazard_fwd: forwarding select for one Execute operand, Memory stage wins over Writeback
module hazard_fwd
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_m,
  input  logic       reg_write_w,
  output fwd_sel_t   fwd
);
  assign fwd = (reg_write_m && rd_m != 5'd0 && rd_m == rs_e) ? FWD_M :
               (reg_write_w && rd_w != 5'd0 && rd_w == rs_e) ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage RV32I pipeline with memory-wait watchdog
// Define HAZARD_PERF_EN to build the saturating performance counters; otherwise they read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           Rs1D,
  input  logic [4:0]           Rs2D,
  input  logic [4:0]           Rs1E,
  input  logic [4:0]           Rs2E,
  input  logic [4:0]           RdE,
  input  logic [1:0]           ResultSrcE,
  input  logic                 PCSrcE,
  input  logic [4:0]           RdM,
  input  logic [4:0]           RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReqM,
  input  logic                 MemReadyM,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 StallE,
  output logic                 StallM,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 FlushW,
  output logic [1:0]           ForwardAE,
  output logic [1:0]           ForwardBE,
  output logic                 MemErr,
  output logic [CNT_WIDTH-1:0] LoadUseCnt,
  output logic [CNT_WIDTH-1:0] MemWaitCnt,
  output logic [CNT_WIDTH-1:0] FlushCnt
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  hz_state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic mem_err_q, mem_err_d;
  logic lw_stall, timeout, mem_stall;
  fwd_sel_t fwd_a, fwd_b;
  hazard_fwd u_fwd_a (.rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_a));
  hazard_fwd u_fwd_b (.rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW), .reg_write_m(RegWriteM), .reg_write_w(RegWriteW), .fwd(fwd_b));
  assign lw_stall  = ResultSrcE == RESULT_LOAD && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
  assign timeout   = state_q == MEM_WAIT && wait_q == WW'(MEM_TIMEOUT - 1) && !MemReadyM;
  assign mem_stall = MemReqM && !MemReadyM && !timeout;
  // wait_q counts stall cycles of the current access, so the first RUN stall counts as one
  always_comb begin
    state_d   = (state_q == RUN) ? (mem_stall ? MEM_WAIT : RUN) : ((MemReadyM || timeout) ? RUN : MEM_WAIT);
    wait_d    = (state_d == MEM_WAIT) ? wait_q + WW'(1) : '0;
    mem_err_d = mem_err_q || timeout;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end
  always_comb begin
    StallF    = rst_n && (mem_stall || lw_stall);
    StallD    = StallF;
    StallE    = rst_n && mem_stall;
    StallM    = StallE;
    FlushW    = !rst_n || mem_stall;
    FlushD    = !rst_n || (!mem_stall && PCSrcE);
    FlushE    = !rst_n || (!mem_stall && (lw_stall || PCSrcE));
    ForwardAE = rst_n ? fwd_a : FWD_RF;
    ForwardBE = rst_n ? fwd_b : FWD_RF;
  end
  assign MemErr = mem_err_q;
`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] lu_q, lu_d, mw_q, mw_d, fl_q, fl_d;
  always_comb begin
    lu_d = lu_q + CNT_WIDTH'(lw_stall && !mem_stall && lu_q != '1);
    mw_d = mw_q + CNT_WIDTH'(mem_stall && mw_q != '1);
    fl_d = fl_q + CNT_WIDTH'(PCSrcE && !mem_stall && fl_q != '1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_q <= '0;
      mw_q <= '0;
      fl_q <= '0;
    end else begin
      lu_q <= lu_d;
      mw_q <= mw_d;
      fl_q <= fl_d;
    end
  end
  assign LoadUseCnt = lu_q;
  assign MemWaitCnt = mw_q;
  assign FlushCnt   = fl_q;
`else
  assign LoadUseCnt = '0;
  assign MemWaitCnt = '0;
  assign FlushCnt   = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
  localparam int T = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] LoadUseCnt, MemWaitCnt, FlushCnt;
  int checks = 0;
  int errors = 0;
  bit m_wait, m_err;
  int m_n, m_lu, m_mw, m_fl;
  always #5 clk = ~clk;
  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .StallF(StallF),
    .StallD(StallD), .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .LoadUseCnt(LoadUseCnt), .MemWaitCnt(MemWaitCnt), .FlushCnt(FlushCnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] fwd_of(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction
  function automatic bit lw();
    return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction
  function automatic bit wd_fire();
    return m_wait && m_n == T - 1 && !MemReadyM;
  endfunction
  function automatic bit ms();
    return MemReqM && !MemReadyM && !wd_fire();
  endfunction
  function automatic int sat(input int v);
    return (v == CMAX) ? v : v + 1;
  endfunction
  task automatic compare();
    bit s, l;
    @(negedge clk);
    s = ms();
    l = lw();
    chk("StallF", 32'(StallF), 32'(rst_n && (s || l)));
    chk("StallD", 32'(StallD), 32'(rst_n && (s || l)));
    chk("StallE", 32'(StallE), 32'(rst_n && s));
    chk("StallM", 32'(StallM), 32'(rst_n && s));
    chk("FlushD", 32'(FlushD), 32'(!rst_n || (!s && PCSrcE)));
    chk("FlushE", 32'(FlushE), 32'(!rst_n || (!s && (l || PCSrcE))));
    chk("FlushW", 32'(FlushW), 32'(!rst_n || s));
    chk("ForwardAE", 32'(ForwardAE), rst_n ? 32'(fwd_of(Rs1E)) : 32'd0);
    chk("ForwardBE", 32'(ForwardBE), rst_n ? 32'(fwd_of(Rs2E)) : 32'd0);
    chk("MemErr", 32'(MemErr), 32'(m_err));
    chk("LoadUseCnt", 32'(LoadUseCnt), PERF ? m_lu : 0);
    chk("MemWaitCnt", 32'(MemWaitCnt), PERF ? m_mw : 0);
    chk("FlushCnt", 32'(FlushCnt), PERF ? m_fl : 0);
  endtask
  task automatic adv();
    bit s, l, t;
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_n = 0; m_err = 0; m_lu = 0; m_mw = 0; m_fl = 0;
    end else begin
      s = ms(); l = lw(); t = wd_fire();
      if (l && !s) m_lu = sat(m_lu);
      if (s) m_mw = sat(m_mw);
      if (PCSrcE && !s) m_fl = sat(m_fl);
      if (t) m_err = 1;
      if (!m_wait) begin
        if (s) begin m_wait = 1; m_n = 1; end
      end else if (MemReadyM || t) begin
        m_wait = 0; m_n = 0;
      end else m_n++;
    end
    #1;
  endtask
  task automatic idle();
    rst_n = 1; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemReadyM = 0;
  endtask
  initial begin
    m_wait = 0; m_err = 0; m_n = 0; m_lu = 0; m_mw = 0; m_fl = 0;
    idle();
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      compare();
      chk("rst_flush", {29'd0, FlushD, FlushE, FlushW}, 32'd7);
      chk("rst_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
      adv();
    end
    idle();
    compare();
    chk("rst_memerr", 32'(MemErr), 32'd0);
    adv();
    RdM = 5; RegWriteM = 1; Rs1E = 5; RdW = 5; RegWriteW = 1;
    compare();
    chk("fwd_m_prio", 32'(ForwardAE), 32'd2);
    adv();
    RdM = 0; RdW = 0;
    compare();
    chk("fwd_x0", 32'(ForwardAE), 32'd0);
    adv();
    idle();
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    compare();
    chk("lu_stall", {29'd0, StallF, StallD, FlushE}, 32'd7);
    adv();
    idle();
    compare();
    chk("lu_once", 32'(StallF), 32'd0);
    chk("lu_cnt", 32'(LoadUseCnt), PERF ? 32'd1 : 32'd0);
    adv();
    PCSrcE = 1;
    compare();
    chk("br_flush", {28'd0, FlushD, FlushE, StallF, StallE}, 32'b1100);
    adv();
    idle();
    compare();
    chk("br_cnt", 32'(FlushCnt), PERF ? 32'd1 : 32'd0);
    adv();
    MemReqM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      compare();
      chk("mw_stall", {27'd0, StallF, StallD, StallE, StallM, FlushW}, 32'h1f);
      chk("mw_defer", {30'd0, FlushD, FlushE}, 32'd0);
      adv();
    end
    MemReadyM = 1;
    compare();
    chk("mw_release", {29'd0, StallF, FlushD, FlushE}, 32'b011);
    adv();
    idle();
    compare();
    chk("mw_cnt", 32'(MemWaitCnt), PERF ? 32'd3 : 32'd0);
    chk("mw_flcnt", 32'(FlushCnt), PERF ? 32'd2 : 32'd0);
    adv();
    MemReqM = 1;
    for (int i = 0; i < 3; i++) begin
      compare();
      chk("wd_stall", 32'(StallM), 32'd1);
      adv();
    end
    compare();
    chk("wd_release", 32'(StallM), 32'd0);
    adv();
    idle();
    for (int i = 0; i < 3; i++) begin
      compare();
      chk("wd_err", 32'(MemErr), 32'd1);
      adv();
    end
    MemReqM = 1; RdM = 5; Rs1E = 5; RegWriteM = 1; PCSrcE = 1;
    compare();
    adv();
    rst_n = 0;
    compare();
    chk("rstw_flush", {29'd0, FlushD, FlushE, FlushW}, 32'd7);
    chk("rstw_stall", {28'd0, StallF, StallD, StallE, StallM}, 32'd0);
    chk("rstw_fwd", 32'(ForwardAE), 32'd0);
    adv();
    idle();
    compare();
    chk("rstw_err", 32'(MemErr), 32'd0);
    chk("rstw_cnt", {LoadUseCnt, MemWaitCnt, FlushCnt}, 32'd0);
    adv();
    MemReqM = 1;
    compare();
    chk("rstw_run", 32'(StallF), 32'd1);
    adv();
    MemReadyM = 1;
    compare();
    chk("rstw_done", 32'(StallF), 32'd0);
    adv();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(63) != 0);
      Rs1D = 5'($urandom_range(3)); Rs2D = 5'($urandom_range(3));
      Rs1E = 5'($urandom_range(3)); Rs2E = 5'($urandom_range(3));
      RdE = 5'($urandom_range(3)); RdM = 5'($urandom_range(3)); RdW = 5'($urandom_range(3));
      ResultSrcE = 2'($urandom_range(3));
      PCSrcE = ($urandom_range(7) == 0);
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      MemReqM = ($urandom_range(2) != 0);
      MemReadyM = ($urandom_range(3) == 0);
      compare();
      adv();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
